// File: rtl/data_cache_pkg.sv
// Shared definitions for the data-cache line buffer: FSM encoding and the
// geometry derivations used by the top level and the word blocks.
package data_cache_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FILL = 2'd1,
      S_WB   = 2'd2
   } state_e;

   localparam int DEF_ADDR_WIDTH = 3;
   localparam int DEF_WORD_BYTES = 4;

   function automatic int calc_words(input int addr_width);
      return 1 << addr_width;
   endfunction

   function automatic int calc_dw(input int word_bytes);
      return 8 * word_bytes;
   endfunction

endpackage

// File: rtl/data_cache_word_block.sv
// One storage word of the line buffer: byte-enable core write port plus a
// full-word load port used by refill. The two ports are never active together.
module data_cache_word_block
   import data_cache_pkg::*;
#(
   parameter int WORD_BYTES = DEF_WORD_BYTES
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      wr_en,
   input  logic [WORD_BYTES-1:0]     wr_be,
   input  logic [8*WORD_BYTES-1:0]   wr_data,
   input  logic                      ld_en,
   input  logic [8*WORD_BYTES-1:0]   ld_data,
   output logic [8*WORD_BYTES-1:0]   q
);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         q <= '0;
      end else if (ld_en) begin
         q <= ld_data;
      end else if (wr_en) begin
         for (int k = 0; k < WORD_BYTES; k++) begin
            if (wr_be[k]) q[8*k +: 8] <= wr_data[8*k +: 8];
         end
      end
   end

endmodule

// File: rtl/data_cache_line_buffer.sv
// One cache line of storage with a combinational read port, core byte writes,
// and sequenced refill (stream in) / writeback (stream out) bursts.
module data_cache_line_buffer
   import data_cache_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int WORD_BYTES = DEF_WORD_BYTES
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [ADDR_WIDTH-1:0]     rd_addr_i,
   output logic [8*WORD_BYTES-1:0]   rd_data_o,
   input  logic [ADDR_WIDTH-1:0]     wr_addr_i,
   input  logic [8*WORD_BYTES-1:0]   wr_data_i,
   input  logic [WORD_BYTES-1:0]     wr_be_i,
   input  logic                      wr_en_i,
   input  logic                      fill_start_i,
   input  logic                      fill_valid_i,
   input  logic [8*WORD_BYTES-1:0]   fill_data_i,
   output logic                      fill_ready_o,
   input  logic                      wb_start_i,
   output logic                      wb_valid_o,
   output logic [8*WORD_BYTES-1:0]   wb_data_o,
   input  logic                      wb_ready_i,
   output logic                      busy_o,
   output logic                      dirty_o,
   output logic                      fill_done_o,
   output logic                      wb_done_o
);

   localparam int WORDS = calc_words(ADDR_WIDTH);
   localparam int DW    = calc_dw(WORD_BYTES);

   state_e                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  beat_q, beat_d;
   logic                   dirty_q, dirty_d;
   logic                   fill_done_q, fill_done_d;
   logic                   wb_done_q, wb_done_d;
   logic                   core_wr, fill_hs, last_beat;
   logic [DW-1:0]          word_q [WORDS];

   // Core writes only land while idle; the core is expected to stall on busy_o.
   assign core_wr   = (state_q == S_IDLE) && wr_en_i;
   assign fill_hs   = (state_q == S_FILL) && fill_valid_i;
   assign last_beat = &beat_q;

   for (genvar i = 0; i < WORDS; i++) begin : g_word
      data_cache_word_block #(
         .WORD_BYTES (WORD_BYTES)
      ) u_word (
         .clk_i   (clk_i),
         .rst_ni  (rst_ni),
         .wr_en   (core_wr && (wr_addr_i == ADDR_WIDTH'(i))),
         .wr_be   (wr_be_i),
         .wr_data (wr_data_i),
         .ld_en   (fill_hs && (beat_q == ADDR_WIDTH'(i))),
         .ld_data (fill_data_i),
         .q       (word_q[i])
      );
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         beat_q      <= '0;
         dirty_q     <= 1'b0;
         fill_done_q <= 1'b0;
         wb_done_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         beat_q      <= beat_d;
         dirty_q     <= dirty_d;
         fill_done_q <= fill_done_d;
         wb_done_q   <= wb_done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      dirty_d     = dirty_q;
      fill_done_d = 1'b0;
      wb_done_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (core_wr && (|wr_be_i)) dirty_d = 1'b1;
            // Writeback wins a simultaneous request; the refill request is dropped.
            if (wb_start_i) begin
               state_d = S_WB;
               beat_d  = '0;
            end else if (fill_start_i) begin
               state_d = S_FILL;
               beat_d  = '0;
            end
         end
         S_FILL: begin
            if (fill_valid_i) begin
               beat_d = beat_q + ADDR_WIDTH'(1);
               if (last_beat) begin
                  state_d     = S_IDLE;
                  dirty_d     = 1'b0;
                  fill_done_d = 1'b1;
               end
            end
         end
         S_WB: begin
            if (wb_ready_i) begin
               beat_d = beat_q + ADDR_WIDTH'(1);
               if (last_beat) begin
                  state_d   = S_IDLE;
                  dirty_d   = 1'b0;
                  wb_done_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            beat_d  = '0;
         end
      endcase
   end

   assign rd_data_o    = word_q[rd_addr_i];
   assign fill_ready_o = (state_q == S_FILL);
   assign wb_valid_o   = (state_q == S_WB);
   assign wb_data_o    = (state_q == S_WB) ? word_q[beat_q] : '0;
   assign busy_o       = (state_q != S_IDLE);
   assign dirty_o      = dirty_q;
   assign fill_done_o  = fill_done_q;
   assign wb_done_o    = wb_done_q;

endmodule

// File: tb/tb_data_cache_line_buffer.sv
// Randomized self-checking bench for data_cache_line_buffer against a
// transaction-level model of the line contents and dirty flag.
module tb_data_cache_line_buffer;

   localparam int AW    = 3;
   localparam int WBY   = 4;
   localparam int WORDS = 8;
   localparam int DW    = 32;

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic [AW-1:0]     rd_addr_i;
   logic [DW-1:0]     rd_data_o;
   logic [AW-1:0]     wr_addr_i;
   logic [DW-1:0]     wr_data_i;
   logic [WBY-1:0]    wr_be_i;
   logic              wr_en_i;
   logic              fill_start_i;
   logic              fill_valid_i;
   logic [DW-1:0]     fill_data_i;
   logic              fill_ready_o;
   logic              wb_start_i;
   logic              wb_valid_o;
   logic [DW-1:0]     wb_data_o;
   logic              wb_ready_i;
   logic              busy_o;
   logic              dirty_o;
   logic              fill_done_o;
   logic              wb_done_o;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] ref_mem [WORDS];
   logic          ref_dirty;

   data_cache_line_buffer #(
      .ADDR_WIDTH (AW),
      .WORD_BYTES (WBY)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .rd_addr_i    (rd_addr_i),
      .rd_data_o    (rd_data_o),
      .wr_addr_i    (wr_addr_i),
      .wr_data_i    (wr_data_i),
      .wr_be_i      (wr_be_i),
      .wr_en_i      (wr_en_i),
      .fill_start_i (fill_start_i),
      .fill_valid_i (fill_valid_i),
      .fill_data_i  (fill_data_i),
      .fill_ready_o (fill_ready_o),
      .wb_start_i   (wb_start_i),
      .wb_valid_o   (wb_valid_o),
      .wb_data_o    (wb_data_o),
      .wb_ready_i   (wb_ready_i),
      .busy_o       (busy_o),
      .dirty_o      (dirty_o),
      .fill_done_o  (fill_done_o),
      .wb_done_o    (wb_done_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #2000000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic quiet_inputs();
      wr_en_i      = 1'b0;
      wr_be_i      = '0;
      wr_addr_i    = '0;
      wr_data_i    = '0;
      fill_start_i = 1'b0;
      fill_valid_i = 1'b0;
      fill_data_i  = '0;
      wb_start_i   = 1'b0;
      wb_ready_i   = 1'b0;
   endtask

   task automatic check_mem(input string tag);
      for (int i = 0; i < WORDS; i++) begin
         rd_addr_i = AW'(i);
         #1;
         chk(tag, rd_data_o, ref_mem[i]);
      end
   endtask

   task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [WBY-1:0] be);
      for (int k = 0; k < WBY; k++)
         if (be[k]) ref_mem[a][8*k +: 8] = d[8*k +: 8];
      if (be != '0) ref_dirty = 1'b1;
   endtask

   task automatic core_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [WBY-1:0] be);
      wr_addr_i = a;
      wr_data_i = d;
      wr_be_i   = be;
      wr_en_i   = 1'b1;
      step();
      wr_en_i   = 1'b0;
      model_write(a, d, be);
   endtask

   // fixed=1: beats 0x10.. with valid dropped for 3 cycles before beat 5.
   task automatic do_fill(input bit chain_wb, input bit fixed);
      logic [DW-1:0] beats [WORDS];
      logic          valid;
      int            k;
      int            cyc;
      int            stall;
      k = 0; cyc = 0; stall = 0;
      for (int i = 0; i < WORDS; i++) beats[i] = fixed ? (32'h10 + 32'(i)) : $urandom;
      fill_start_i = 1'b1;
      step();
      fill_start_i = 1'b0;
      while (k < WORDS && cyc < 300) begin
         if (fixed) begin
            valid = !(k == 5 && stall < 3);
            if (!valid) stall++;
         end else begin
            valid = ($urandom_range(0, 3) != 0);
         end
         fill_valid_i = valid;
         fill_data_i  = valid ? beats[k] : $urandom;
         rd_addr_i    = AW'(k);
         @(negedge clk_i);
         chk("fill_ready", fill_ready_o, 1);
         chk("fill_busy", busy_o, 1);
         chk("fill_done_early", fill_done_o, 0);
         chk("fill_wb_valid", wb_valid_o, 0);
         if (!valid) chk("fill_stall_word", rd_data_o, ref_mem[k]);
         step();
         if (valid) begin
            ref_mem[k] = beats[k];
            chk("fill_word_now", rd_data_o, beats[k]);
            k++;
         end
         cyc++;
      end
      chk("fill_beats", k, WORDS);
      fill_valid_i = 1'b0;
      ref_dirty    = 1'b0;
      if (chain_wb) wb_start_i = 1'b1;
      @(negedge clk_i);
      chk("fill_done", fill_done_o, 1);
      chk("fill_end_busy", busy_o, 0);
      chk("fill_end_dirty", dirty_o, 0);
      chk("fill_end_ready", fill_ready_o, 0);
      step();
      wb_start_i = 1'b0;
      chk("fill_done_once", fill_done_o, 0);
      chk("fill_chain_busy", busy_o, chain_wb);
   endtask

   task automatic do_wb(input bit started, input bit toggle, input bit poke);
      logic [DW-1:0] exp [WORDS];
      logic          rdy;
      int            k;
      int            cyc;
      k = 0; cyc = 0;
      for (int i = 0; i < WORDS; i++) exp[i] = ref_mem[i];
      if (!started) begin
         wb_start_i = 1'b1;
         step();
         wb_start_i = 1'b0;
      end
      while (k < WORDS && cyc < 300) begin
         rdy        = toggle ? (cyc % 2 == 0) : 1'($urandom);
         wb_ready_i = rdy;
         if (poke) begin
            wr_en_i      = 1'b1;
            wr_be_i      = 4'hF;
            wr_addr_i    = AW'($urandom);
            wr_data_i    = $urandom;
            fill_start_i = 1'($urandom);
            wb_start_i   = 1'($urandom);
         end
         @(negedge clk_i);
         chk("wb_valid", wb_valid_o, 1);
         chk("wb_data", wb_data_o, exp[k]);
         chk("wb_fill_ready", fill_ready_o, 0);
         chk("wb_done_early", wb_done_o, 0);
         step();
         if (rdy) k++;
         cyc++;
      end
      chk("wb_beats", k, WORDS);
      quiet_inputs();
      ref_dirty = 1'b0;
      @(negedge clk_i);
      chk("wb_done", wb_done_o, 1);
      chk("wb_end_busy", busy_o, 0);
      chk("wb_end_valid", wb_valid_o, 0);
      chk("wb_end_data", wb_data_o, 0);
      chk("wb_end_dirty", dirty_o, 0);
      step();
      chk("wb_done_once", wb_done_o, 0);
      chk("wb_no_follow", busy_o, 0);
      check_mem("wb_mem_kept");
   endtask

   int nw;
   int op;

   initial begin
      rst_ni    = 1'b0;
      rd_addr_i = '0;
      quiet_inputs();
      for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
      ref_dirty = 1'b0;
      step();
      step();
      rst_ni = 1'b1;
      step();
      chk("rst_busy", busy_o, 0);
      chk("rst_dirty", dirty_o, 0);
      chk("rst_fill_ready", fill_ready_o, 0);
      chk("rst_wb_valid", wb_valid_o, 0);
      chk("rst_fill_done", fill_done_o, 0);
      chk("rst_wb_done", wb_done_o, 0);
      check_mem("rst_mem");

      // Zero byte enables leave storage and dirty alone.
      core_write(3'd3, 32'hFFFF_FFFF, 4'b0000);
      chk("be0_dirty", dirty_o, 0);
      check_mem("be0_mem");

      core_write(3'd2, 32'hAABB_CCDD, 4'b1111);
      core_write(3'd2, 32'h0000_1100, 4'b0010);
      rd_addr_i = 3'd2;
      #1;
      chk("byte_merge", rd_data_o, 32'hAABB_11DD);
      chk("write_dirty", dirty_o, 1);

      do_fill(1'b0, 1'b1);
      check_mem("fill_fixed_mem");
      chk("fill_fixed_dirty", dirty_o, 0);

      core_write(3'd5, $urandom, 4'hF);
      chk("w5_dirty", dirty_o, 1);
      do_wb(1'b0, 1'b1, 1'b0);

      // Both starts together plus ignored traffic during writeback.
      core_write(3'd1, $urandom, 4'b0101);
      fill_start_i = 1'b1;
      wb_start_i   = 1'b1;
      step();
      fill_start_i = 1'b0;
      wb_start_i   = 1'b0;
      chk("both_start_wb", wb_valid_o, 1);
      chk("both_start_nofill", fill_ready_o, 0);
      do_wb(1'b1, 1'b0, 1'b1);

      // A write in the start cycle is seen by writeback beat 0.
      wr_addr_i  = 3'd0;
      wr_data_i  = $urandom;
      wr_be_i    = 4'b1001;
      wr_en_i    = 1'b1;
      wb_start_i = 1'b1;
      step();
      model_write(3'd0, wr_data_i, 4'b1001);
      quiet_inputs();
      do_wb(1'b1, 1'b0, 1'b0);

      for (int it = 0; it < 8; it++) begin
         nw = $urandom_range(1, 4);
         for (int j = 0; j < nw; j++) core_write(AW'($urandom), $urandom, WBY'($urandom));
         chk("rand_dirty", dirty_o, ref_dirty);
         check_mem("rand_mem");
         op = $urandom_range(0, 2);
         if (op == 0) begin
            do_fill(1'b0, 1'b0);
            check_mem("rand_fill_mem");
         end else if (op == 1) begin
            do_wb(1'b0, 1'b0, 1'b1);
         end else begin
            do_fill(1'b1, 1'b0);
            do_wb(1'b1, 1'b0, 1'b0);
         end
      end

      // Asynchronous reset in the middle of a refill.
      core_write(3'd6, 32'h1234_5678, 4'hF);
      fill_start_i = 1'b1;
      step();
      fill_start_i = 1'b0;
      fill_valid_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         fill_data_i = 32'h100 + 32'(i);
         step();
      end
      fill_valid_i = 1'b0;
      chk("pre_rst_busy", busy_o, 1);
      rd_addr_i = 3'd1;
      #1;
      chk("pre_rst_word1", rd_data_o, 32'h101);
      rst_ni = 1'b0;
      #1;
      chk("arst_busy", busy_o, 0);
      chk("arst_ready", fill_ready_o, 0);
      chk("arst_dirty", dirty_o, 0);
      chk("arst_word1", rd_data_o, 0);
      for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
      ref_dirty = 1'b0;
      step();
      rst_ni = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         chk("arst_no_done", fill_done_o, 0);
         chk("arst_idle", busy_o, 0);
         step();
      end
      check_mem("arst_mem");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
